// File: rtl/game_pkg.sv
// Shared types and widths for the maze game round logic.
// Holds the round state encoding seen by the HUD and the score helper.
package game_pkg;

    localparam int SCORE_W = 16;
    localparam int TIME_W  = 10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESTART  = 3'd1,
        ST_PLAYING   = 3'd2,
        ST_LEVEL_WON = 3'd3,
        ST_GAME_WON  = 3'd4,
        ST_LOST      = 3'd5
    } round_state_t;

    // Adds banked seconds to the score, pinning at all-ones instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] score,
                                                   input logic [TIME_W-1:0]  secs);
        logic [SCORE_W:0] sum;
        sum = {1'b0, score} + {{(SCORE_W - TIME_W + 1){1'b0}}, secs};
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Seconds prescaler: counts 0..CYCLES_PER_SEC-1 and flags the wrap cycle.
// The tick depends only on the count, so callers may derive clear from it.
module sec_prescaler #(
    parameter int CYCLES_PER_SEC = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_in,
    output logic tick_out
);

    localparam int CNT_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_SEC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_in || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_out = (cnt_q == CNT_LAST);

endmodule

// File: rtl/round_sequencer.sv
// Game-round controller: 3-2-1 pre-start, timer arming, exit/expiry handling,
// score banking and level advance for a multi-level maze run.
module round_sequencer
    import game_pkg::*;
#(
    parameter int CYCLES_PER_SEC = 100_000_000,
    parameter int NUM_LEVELS     = 4,
    parameter int PRESTART_SECS  = 3,
    parameter int HOLD_SECS      = 2,
    parameter int LEVEL_W        = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic               clk_100mhz_in,
    input  logic               rst_n_in,
    input  logic               start_btn_in,
    input  logic               exit_reached_in,
    input  logic               timer_done_in,
    input  logic [TIME_W-1:0]  time_in,
    output logic               timer_start_out,
    output logic               timer_clear_out,
    output logic [2:0]         state_out,
    output logic [1:0]         countdown_out,
    output logic [LEVEL_W-1:0] level_out,
    output logic [SCORE_W-1:0] score_out,
    output logic               game_over_out,
    output logic               game_won_out
);

    localparam int HOLD_W = (HOLD_SECS > 1) ? $clog2(HOLD_SECS) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST   = HOLD_W'(HOLD_SECS - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_LAST  = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [1:0]         PRESTART_CD = 2'(PRESTART_SECS);

    round_state_t       state_q,       state_d;
    logic [1:0]         countdown_q,   countdown_d;
    logic [LEVEL_W-1:0] level_q,       level_d;
    logic [SCORE_W-1:0] score_q,       score_d;
    logic [HOLD_W-1:0]  hold_cnt_q,    hold_cnt_d;
    logic               timer_start_q, timer_start_d;
    logic               timer_clear_q, timer_clear_d;
    logic               game_over_q,   game_over_d;
    logic               game_won_q,    game_won_d;

    logic tick;
    logic prescale_clear;

    // Prescaler only runs inside PRESTART/LEVEL_WON and restarts on each state entry.
    assign prescale_clear = (state_d != state_q) ||
                            !((state_q == ST_PRESTART) || (state_q == ST_LEVEL_WON));

    sec_prescaler #(
        .CYCLES_PER_SEC(CYCLES_PER_SEC)
    ) u_prescaler (
        .clk      (clk_100mhz_in),
        .rst_n    (rst_n_in),
        .clear_in (prescale_clear),
        .tick_out (tick)
    );

    always_comb begin
        state_d       = state_q;
        countdown_d   = countdown_q;
        level_d       = level_q;
        score_d       = score_q;
        hold_cnt_d    = hold_cnt_q;
        timer_start_d = 1'b0;
        timer_clear_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_GAME_WON, ST_LOST: begin
                if (start_btn_in) begin
                    state_d     = ST_PRESTART;
                    level_d     = '0;
                    score_d     = '0;
                    countdown_d = PRESTART_CD;
                end
            end
            ST_PRESTART: begin
                if (tick) begin
                    if (countdown_q == 2'd1) begin
                        state_d       = ST_PLAYING;
                        countdown_d   = 2'd0;
                        timer_start_d = 1'b1;
                    end else begin
                        countdown_d = countdown_q - 2'd1;
                    end
                end
            end
            ST_PLAYING: begin
                // Reaching the exit outranks a same-cycle expiry.
                if (exit_reached_in) begin
                    state_d       = ST_LEVEL_WON;
                    score_d       = sat_add(score_q, time_in);
                    timer_clear_d = 1'b1;
                    hold_cnt_d    = '0;
                end else if (timer_done_in) begin
                    state_d = ST_LOST;
                end
            end
            ST_LEVEL_WON: begin
                if (tick) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        if (level_q == LEVEL_LAST) begin
                            state_d = ST_GAME_WON;
                        end else begin
                            state_d     = ST_PRESTART;
                            level_d     = level_q + 1'b1;
                            countdown_d = PRESTART_CD;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        game_over_d = (state_d == ST_LOST);
        game_won_d  = (state_d == ST_GAME_WON);
    end

    always_ff @(posedge clk_100mhz_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= ST_IDLE;
            countdown_q   <= 2'd0;
            level_q       <= '0;
            score_q       <= '0;
            hold_cnt_q    <= '0;
            timer_start_q <= 1'b0;
            timer_clear_q <= 1'b0;
            game_over_q   <= 1'b0;
            game_won_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            countdown_q   <= countdown_d;
            level_q       <= level_d;
            score_q       <= score_d;
            hold_cnt_q    <= hold_cnt_d;
            timer_start_q <= timer_start_d;
            timer_clear_q <= timer_clear_d;
            game_over_q   <= game_over_d;
            game_won_q    <= game_won_d;
        end
    end

    assign state_out       = state_q;
    assign countdown_out   = countdown_q;
    assign level_out       = level_q;
    assign score_out       = score_q;
    assign timer_start_out = timer_start_q;
    assign timer_clear_out = timer_clear_q;
    assign game_over_out   = game_over_q;
    assign game_won_out    = game_won_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: table of per-edge vectors through a scoreboard,
// plus async-reset and score-saturation sequences on a second instance.
module tb_round_sequencer;

    typedef struct {
        int          skip;
        logic        start;
        logic        exitr;
        logic        done;
        logic [9:0]  tin;
        logic [2:0]  st;
        logic [1:0]  cd;
        logic        lvl;
        logic [15:0] score;
        logic        ts;
        logic        tc;
        logic        over;
        logic        won;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start_btn, exit_reached, timer_done;
    logic [9:0]  time_v;
    logic        timer_start, timer_clear, game_over, game_won;
    logic [2:0]  state;
    logic [1:0]  countdown;
    logic [0:0]  level;
    logic [15:0] score;

    logic        s_rst_n, s_start, s_exit, s_done;
    logic [9:0]  s_time;
    logic        s_ts, s_tc, s_over, s_won;
    logic [2:0]  s_state;
    logic [1:0]  s_cd;
    logic [6:0]  s_level;
    logic [15:0] s_score;

    round_sequencer #(
        .CYCLES_PER_SEC(4),
        .NUM_LEVELS    (2),
        .PRESTART_SECS (3),
        .HOLD_SECS     (2)
    ) dut (
        .clk_100mhz_in  (clk),
        .rst_n_in       (rst_n),
        .start_btn_in   (start_btn),
        .exit_reached_in(exit_reached),
        .timer_done_in  (timer_done),
        .time_in        (time_v),
        .timer_start_out(timer_start),
        .timer_clear_out(timer_clear),
        .state_out      (state),
        .countdown_out  (countdown),
        .level_out      (level),
        .score_out      (score),
        .game_over_out  (game_over),
        .game_won_out   (game_won)
    );

    // Many short levels so the score can be driven up to saturation.
    round_sequencer #(
        .CYCLES_PER_SEC(1),
        .NUM_LEVELS    (66),
        .PRESTART_SECS (1),
        .HOLD_SECS     (1)
    ) dut_sat (
        .clk_100mhz_in  (clk),
        .rst_n_in       (s_rst_n),
        .start_btn_in   (s_start),
        .exit_reached_in(s_exit),
        .timer_done_in  (s_done),
        .time_in        (s_time),
        .timer_start_out(s_ts),
        .timer_clear_out(s_tc),
        .state_out      (s_state),
        .countdown_out  (s_cd),
        .level_out      (s_level),
        .score_out      (s_score),
        .game_over_out  (s_over),
        .game_won_out   (s_won)
    );

    int   compared   = 0;
    int   mismatched = 0;
    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(int skip, int s, int e, int d, int t,
                                int st, int cd, int l, int sc,
                                int ts, int tc, int ov, int wn);
        vec_t v;
        v.skip  = skip;
        v.start = 1'(s);
        v.exitr = 1'(e);
        v.done  = 1'(d);
        v.tin   = 10'(t);
        v.st    = 3'(st);
        v.cd    = 2'(cd);
        v.lvl   = 1'(l);
        v.score = 16'(sc);
        v.ts    = 1'(ts);
        v.tc    = 1'(tc);
        v.over  = 1'(ov);
        v.won   = 1'(wn);
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        repeat (v.skip) @(negedge clk);
        start_btn    = v.start;
        exit_reached = v.exitr;
        timer_done   = v.done;
        time_v       = v.tin;
        sb.push_back(v);
        @(negedge clk);
        start_btn    = 1'b0;
        exit_reached = 1'b0;
        timer_done   = 1'b0;
        time_v       = 10'd0;
    endtask

    task automatic checkOutput(input string name);
        vec_t e;
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL %s: scoreboard empty, nothing expected", name);
        end else begin
            e = sb.pop_front();
            if ({state, countdown, level, score, timer_start, timer_clear, game_over, game_won} !==
                {e.st, e.cd, e.lvl, e.score, e.ts, e.tc, e.over, e.won}) begin
                mismatched++;
                $display("[TB] FAIL %s: got st=%0d cd=%0d lvl=%0d score=%0d ts=%b tc=%b over=%b won=%b, expected st=%0d cd=%0d lvl=%0d score=%0d ts=%b tc=%b over=%b won=%b",
                         name, state, countdown, level, score, timer_start, timer_clear, game_over, game_won,
                         e.st, e.cd, e.lvl, e.score, e.ts, e.tc, e.over, e.won);
            end
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   tval;
        int   model;
        int   w;
        logic timed_out;

        rst_n = 1'b0; start_btn = 1'b0; exit_reached = 1'b0; timer_done = 1'b0; time_v = 10'd0;
        s_rst_n = 1'b0; s_start = 1'b0; s_exit = 1'b0; s_done = 1'b0; s_time = 10'd0;

        //           skip st ex dn tin  st cd l score ts tc ov wn
        vecs.push_back(mk(0, 1, 0, 0, 0,   1, 3, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0, 0,   1, 3, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 2, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(3, 0, 0, 0, 0,   1, 1, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0, 0,   1, 1, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   2, 0, 0, 0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   2, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 37,  3, 0, 0, 37, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   3, 0, 0, 37, 0, 0, 0, 0));
        vecs.push_back(mk(5, 0, 0, 0, 0,   3, 0, 0, 37, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 3, 1, 37, 0, 0, 0, 0));
        vecs.push_back(mk(11, 0, 0, 0, 0,  2, 0, 1, 37, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 20,  3, 0, 1, 57, 0, 1, 0, 0));
        vecs.push_back(mk(7, 0, 0, 0, 0,   4, 0, 1, 57, 0, 0, 0, 1));
        vecs.push_back(mk(2, 0, 1, 1, 0,   4, 0, 1, 57, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0,   1, 3, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(11, 0, 0, 0, 0,  2, 0, 0, 0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 5,   5, 0, 0, 0,  0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 9,   5, 0, 0, 0,  0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,   1, 3, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(11, 0, 0, 0, 0,  2, 0, 0, 0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0,   3, 0, 0, 0,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0,   3, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(6, 0, 0, 0, 0,   1, 3, 1, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,   1, 3, 1, 0,  0, 0, 0, 0));

        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        checkOutput("reset");
        rst_n   = 1'b1;
        s_rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i));
        end

        // Asynchronous reset asserted mid-PRESTART, away from any clock edge.
        #2 rst_n = 1'b0;
        #1 checkValue("async_reset_outputs",
                      {17'd0, state, countdown, level, score, timer_start, timer_clear, game_over, game_won},
                      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkValue("idle_after_reset", {29'd0, state}, 32'd0);

        // Saturation: 64 x 1023 = 0xFFC0, +48 = 0xFFF0, +600 clamps to 0xFFFF.
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        model = 0;
        timed_out = 1'b0;
        for (int i = 0; i < 66; i++) begin
            tval = (i < 64) ? 1023 : ((i == 64) ? 48 : 600);
            w = 0;
            while (w < 20 && s_state != 3'd2) begin
                @(negedge clk);
                w++;
            end
            if (s_state != 3'd2) begin
                timed_out = 1'b1;
                break;
            end
            s_exit = 1'b1;
            s_time = 10'(tval);
            @(negedge clk);
            s_exit = 1'b0;
            s_time = 10'd0;
            model = (model + tval > 65535) ? 65535 : model + tval;
            if (i >= 63) checkValue($sformatf("sat_score_%0d", i), {16'd0, s_score}, 32'(model));
            if (i == 65) checkValue("sat_level", {25'd0, s_level}, 32'd65);
        end
        checkValue("sat_wait_playing", {31'd0, timed_out}, 32'd0);
        w = 0;
        while (w < 5 && s_state != 3'd4) begin
            @(negedge clk);
            w++;
        end
        checkValue("sat_game_won", {28'd0, s_state, s_won}, {28'd0, 3'd4, 1'b1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Game-round controller that sequences the countdown timer block for a multi-level maze run.
- Runs a 3-2-1 pre-start countdown, then arms the timer and watches for the player reaching the exit or the timer expiring.
- Banks remaining seconds into the score and advances through the levels.
- Sits between the input/game-logic layer and the timer; its outputs feed the HUD renderer.

Parameters:
- CYCLES_PER_SEC, default 100_000_000: clock cycles per second for the pre-start and hold prescaler (benches use 4).
- NUM_LEVELS, default 4: number of levels per game, must be ≥1.
- PRESTART_SECS, default 3: pre-start countdown length, 1..3.
- HOLD_SECS, default 2: seconds spent in LEVEL_WON before moving on.
- LEVEL_W, default $clog2(NUM_LEVELS) (min 1): width of level_out.

Ports:
- clk_100mhz_in  in  1  system clock
- rst_n_in  in  1  reset; asynchronous, active-low
- start_btn_in  in  1  debounced one-cycle start pulse
- exit_reached_in  in  1  level signal, player is on the exit cell
- timer_done_in  in  1  one-cycle pulse from timer, time expired
- time_in  in  10  seconds remaining, from timer
- timer_start_out  out  1  one-cycle pulse to arm timer
- timer_clear_out  out  1  one-cycle pulse, aborts timer, ORed into the timer's reset by the top level
- state_out  out  3  encoded current state, for the HUD
- countdown_out  out  2  pre-start digit (3,2,1), 0 outside PRESTART
- level_out  out  LEVEL_W  current level index, 0-based
- score_out  out  16  accumulated score
- game_over_out  out  1  high in LOST
- game_won_out  out  1  high in GAME_WON

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values (while rst_n_in=0, asynchronous):
  - state=IDLE, prescaler=0.
  - countdown_out=0, level_out=0, score_out=0.
  - All pulse and flag outputs are 0.
- States: IDLE=0, PRESTART=1, PLAYING=2, LEVEL_WON=3, GAME_WON=4, LOST=5.
- Prescaler: counts 0..CYCLES_PER_SEC-1 in PRESTART and LEVEL_WON only. It is cleared on every state entry; one "tick" occurs when it wraps.
- IDLE: on start_btn_in → PRESTART with level=0, score=0, countdown_out=PRESTART_SECS.
- PRESTART:
  - On each tick, countdown_out decrements.
  - On the tick where countdown_out==1: next cycle state=PLAYING and countdown_out=0.
  - timer_start_out is high in that same cycle (registered, coincident with entering PLAYING).
  - Total PRESTART duration is PRESTART_SECS*CYCLES_PER_SEC cycles.
- PLAYING, priority exit_reached_in > timer_done_in:
  - exit_reached_in=1: score += time_in (zero-extended), saturating at 16'hFFFF. timer_clear_out pulses one cycle. Next state is LEVEL_WON.
  - Else timer_done_in=1: next state is LOST and game_over_out=1.
  - If both are asserted in the same cycle, the exit wins and adds time_in (0).
- LEVEL_WON: after HOLD_SECS ticks:
  - If level==NUM_LEVELS-1 → GAME_WON.
  - Otherwise level increments and the block enters PRESTART with countdown_out=PRESTART_SECS. score is kept.
- LOST / GAME_WON:
  - Flags are held.
  - On start_btn_in: flags clear, level=0, score=0, and the block enters PRESTART directly.
- Ignored inputs:
  - start_btn_in outside IDLE/LOST/GAME_WON.
  - timer_done_in and exit_reached_in outside PLAYING.
  - A stale timer_done_in arriving the cycle after a clear does nothing.
- Pulses: timer_start_out and timer_clear_out are never high simultaneously; each is exactly one cycle wide.
- Reset mid-operation: the asynchronous return to IDLE values must abort any pending pulse. The timer is reset by the same system reset at top level.
- The controller never depends on time_in outside PLAYING.

Decomposition:
- Shared package game_pkg: state enum round_state_t with the explicit 3-bit encoding above, SCORE_W=16, TIME_W=10.
- One natural sub-module, sec_prescaler: clear input, tick output, parameter CYCLES_PER_SEC, async active-low reset. Reusable by other HUD timing blocks.
- Everything else stays in a single FSM always_ff block plus next-state logic.

Test Plan:
- Bench uses CYCLES_PER_SEC=4, NUM_LEVELS=2, PRESTART_SECS=3, HOLD_SECS=2.
- Reset, then start pulse → countdown_out steps 3,2,1 every 4 cycles. state=PLAYING with one timer_start_out pulse exactly 12 cycles after the start pulse.
- PLAYING, time_in=37, exit_reached_in=1 → score_out=37, one timer_clear_out pulse, LEVEL_WON for 8 cycles, then level_out=1 and PRESTART with countdown_out=3.
- Level 1 exit with time_in=20 → score_out=57, LEVEL_WON, then GAME_WON with game_won_out=1. A further start pulse → score_out=0, level_out=0, PRESTART.
- PLAYING, timer_done_in pulse → LOST with game_over_out=1. exit_reached_in afterwards ignored (score unchanged). Start pulse → PRESTART with game_over_out=0.
- Same cycle exit_reached_in=1, timer_done_in=1, time_in=0 → LEVEL_WON, score unchanged, game_over_out stays 0.
- Preload score 16'hFFF0, exit with time_in=600 → score_out=16'hFFFF. Separately, deassert rst_n_in mid-PRESTART between clock edges → all outputs read 0 immediately and state_out=IDLE.
